// File: rtl/umi_pkg.sv
// umi_pkg: shared UMI constants and the request arbiter state type
package umi_pkg;

    localparam int UMI_EOM_BIT = 22;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/umi_rr_pick.sv
// umi_rr_pick: one-hot pick from a request vector, round-robin from ptr or lowest index first
module umi_rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    input  logic          i_mode,
    output logic [N-1:0]  o_pick
);

    logic [PW-1:0] w_idx;
    logic          w_found;

    // Scan requesters starting at ptr (mode=0) or at 0 (mode=1); first hit wins
    always_comb begin
        o_pick  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = i_mode ? PW'(i) : PW'((int'(i_ptr) + i) % N);
            if (!w_found && i_req[w_idx]) begin
                o_pick[w_idx] = 1'b1;
                w_found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/umi_req_arbiter.sv
// umi_req_arbiter: shares one UMI request channel among N requesters without splitting messages
module umi_req_arbiter
    import umi_pkg::*;
#(
    parameter int N      = 4,
    parameter int CW     = 32,
    parameter int AW     = 64,
    parameter int DW     = 128,
    parameter int EOMBIT = UMI_EOM_BIT
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            mode,
    input  logic [N-1:0]    mask,
    input  logic [N-1:0]    umi_in_valid,
    input  logic [N*CW-1:0] umi_in_cmd,
    input  logic [N*AW-1:0] umi_in_dstaddr,
    input  logic [N*AW-1:0] umi_in_srcaddr,
    input  logic [N*DW-1:0] umi_in_data,
    output logic [N-1:0]    umi_in_ready,
    output logic            umi_out_valid,
    output logic [CW-1:0]   umi_out_cmd,
    output logic [AW-1:0]   umi_out_dstaddr,
    output logic [AW-1:0]   umi_out_srcaddr,
    output logic [DW-1:0]   umi_out_data,
    input  logic            umi_out_ready,
    output logic [N-1:0]    grant
);

    localparam int PW = $clog2(N);

    arb_state_t    r_state, w_state_nxt;
    logic [N-1:0]  r_gnt, w_gnt_nxt, w_req, w_pick, w_grant;
    logic [PW-1:0] r_ptr, w_ptr_nxt, w_gidx, w_ptr_inc;
    logic          r_active, w_hs, w_eom;

    assign w_req = umi_in_valid & ~mask;

    umi_rr_pick #(.N(N), .PW(PW)) u_pick (
        .i_req  (w_req),
        .i_ptr  (r_ptr),
        .i_mode (mode),
        .o_pick (w_pick)
    );

    // A locked message ignores mask and keeps its grant even while its valid is low
    assign w_grant       = !r_active ? '0 : (r_state == BUSY) ? r_gnt : w_pick;
    assign umi_out_valid = r_active & ((r_state == BUSY) ? |(umi_in_valid & r_gnt) : |w_req);
    assign grant         = w_grant;
    assign umi_in_ready  = w_grant & {N{umi_out_ready}};
    assign w_hs          = umi_out_valid & umi_out_ready;
    assign w_eom         = umi_out_cmd[EOMBIT];
    assign w_ptr_inc     = (w_gidx == PW'(N - 1)) ? '0 : w_gidx + PW'(1);

    // AND-OR mux of the granted requester's fields; zero when nothing is granted
    always_comb begin
        umi_out_cmd     = '0;
        umi_out_dstaddr = '0;
        umi_out_srcaddr = '0;
        umi_out_data    = '0;
        for (int i = 0; i < N; i++) begin
            umi_out_cmd     = umi_out_cmd     | (umi_in_cmd[i*CW +: CW]     & {CW{w_grant[i]}});
            umi_out_dstaddr = umi_out_dstaddr | (umi_in_dstaddr[i*AW +: AW] & {AW{w_grant[i]}});
            umi_out_srcaddr = umi_out_srcaddr | (umi_in_srcaddr[i*AW +: AW] & {AW{w_grant[i]}});
            umi_out_data    = umi_out_data    | (umi_in_data[i*DW +: DW]    & {DW{w_grant[i]}});
        end
    end

    // Binary index of the one-hot grant, used to advance the round-robin pointer
    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < N; i++) w_gidx = w_gidx | (w_grant[i] ? PW'(i) : '0);
    end

    // Lock on any offer that does not finish a message; release on the EOM handshake
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        if (r_state == IDLE) begin
            if (umi_out_valid && !(w_hs && w_eom)) begin
                w_state_nxt = BUSY;
                w_gnt_nxt   = w_grant;
            end
        end else if (w_hs && w_eom) begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
        end
        if (w_hs && w_eom && !mode) w_ptr_nxt = w_ptr_inc;
    end

    // Arbitration state registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Outputs stay quiet until the first clock edge after reset release
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) r_active <= 1'b0;
        else         r_active <= 1'b1;
    end

endmodule
